// File: rtl/mem_copy_engine.sv
// mem_copy_engine: word-granular block copy over a single-cycle memory port
// Ports: clk, rst_n (async, active-low); start, src_addr, dst_addr, word_count (request);
//        busy, done, err (status); mem_addr, mem_enable, mem_wr, mem_wdata (to memory);
//        mem_rdata (combinational read data from memory).
module mem_copy_engine #(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [15:0]           word_count,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_enable,
  output logic                  mem_wr,
  output logic [15:0]           mem_wdata,
  input  logic [15:0]           mem_rdata
);
  typedef enum logic [2:0] {IDLE, READ, WRITE, FIN, ERR} state_t;
  state_t state, next;
  logic [ADDR_WIDTH-1:0] src, dst;
  logic [15:0] cnt, data;
  logic misaligned, accept;
  always_comb begin
    misaligned = src_addr[0] | dst_addr[0];
    accept = (state == IDLE) && start && !misaligned && (word_count != 16'd0);
    next = state == IDLE  ? (!start ? IDLE : misaligned ? ERR : word_count == 16'd0 ? FIN : READ)
         : state == READ  ? WRITE
         : state == WRITE ? (cnt == 16'd1 ? FIN : READ)
         : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      src   <= '0;
      dst   <= '0;
      cnt   <= '0;
      data  <= '0;
    end else begin
      state <= next;
      if (accept) begin
        src <= src_addr;
        dst <= dst_addr;
        cnt <= word_count;
      end
      if (state == READ) data <= mem_rdata;
      // address wrap past the top of memory is intentional and silent
      if (state == WRITE) begin
        src <= src + ADDR_WIDTH'(2);
        dst <= dst + ADDR_WIDTH'(2);
        cnt <= cnt - 16'd1;
      end
    end
  end
  assign busy       = (state == READ) || (state == WRITE);
  assign done       = state == FIN;
  assign err        = state == ERR;
  assign mem_enable = busy;
  assign mem_wr     = state == WRITE;
  assign mem_addr   = state == READ ? src : state == WRITE ? dst : '0;
  assign mem_wdata  = state == WRITE ? data : 16'd0;
endmodule

// File: tb/tb_mem_copy_engine.sv
// tb_mem_copy_engine: directed self-checking bench with a behavioural 64 KiB word memory
module tb_mem_copy_engine;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] src_addr = '0, dst_addr = '0, word_count = '0;
  logic        busy, done, err, mem_enable, mem_wr;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic [15:0] mem [0:32767];
  logic        poke_en = 1'b0;
  logic [15:0] poke_a = '0, poke_d = '0;
  int checks = 0;
  int errors = 0;

  mem_copy_engine #(.ADDR_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .word_count(word_count),
    .busy(busy), .done(done), .err(err),
    .mem_addr(mem_addr), .mem_enable(mem_enable), .mem_wr(mem_wr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[15:1]];

  always @(posedge clk) begin
    if (mem_enable && mem_wr) mem[mem_addr[15:1]] <= mem_wdata;
    else if (poke_en) mem[poke_a[15:1]] <= poke_d;
  end

  task automatic poke(input logic [15:0] a, input logic [15:0] d);
    poke_a = a;
    poke_d = d;
    poke_en = 1'b1;
    @(posedge clk); #1;
    poke_en = 1'b0;
  endtask

  task automatic launch(input logic [15:0] s, input logic [15:0] d, input logic [15:0] n);
    src_addr = s;
    dst_addr = d;
    word_count = n;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic test_reset;
    checks++;
    if ({busy, done, err, mem_enable, mem_wr, mem_addr, mem_wdata} !== 37'd0) begin
      errors++;
      $display("FAIL reset_outputs got %h exp 0", {busy, done, err, mem_enable, mem_wr, mem_addr, mem_wdata});
    end
  endtask

  task automatic test_basic_copy;
    logic [15:0] dat [3];
    logic [36:0] got, exp;
    logic [15:0] ea, ed;
    logic eb, ew;
    dat[0] = 16'h1111; dat[1] = 16'h2222; dat[2] = 16'h3333;
    for (int i = 0; i < 3; i++) begin
      poke(16'h0100 + 16'(2 * i), dat[i]);
      poke(16'h0200 + 16'(2 * i), 16'h0000);
    end
    launch(16'h0100, 16'h0200, 16'd3);
    for (int c = 1; c <= 8; c++) begin
      eb = c <= 6;
      ew = eb && (c % 2 == 0);
      ea = !eb ? 16'h0 : (c % 2 == 1) ? 16'h0100 + 16'(c - 1) : 16'h0200 + 16'(c - 2);
      ed = ew ? dat[(c - 2) / 2] : 16'h0;
      exp = {eb, c == 7, 1'b0, eb, ew, ea, ed};
      got = {busy, done, err, mem_enable, mem_wr, mem_addr, mem_wdata};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL basic_cycle%0d got %h exp %h", c, got, exp);
      end
      // start pulses while busy and in FIN must be ignored
      if (c == 3 || c == 7) begin
        src_addr = 16'h0300;
        dst_addr = 16'h0200;
        word_count = 16'd5;
        start = 1'b1;
      end else start = 1'b0;
      @(posedge clk); #1;
    end
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem[16'h0100 + 16'(i)] !== (i < 3 ? dat[i] : 16'h0000) && i < 3) begin
        errors++;
        $display("FAIL basic_mem%0d got %h exp %h", i, mem[16'h0100 + 16'(i)], dat[i % 3]);
      end
    end
  endtask

  task automatic test_zero_count;
    poke(16'h0020, 16'hABCD);
    launch(16'h0010, 16'h0020, 16'd0);
    checks++;
    if ({busy, done, err, mem_enable, mem_wr} !== 5'b01000) begin
      errors++;
      $display("FAIL zero_cycle1 got %b exp 01000", {busy, done, err, mem_enable, mem_wr});
    end
    @(posedge clk); #1;
    checks++;
    if ({busy, done, err, mem_enable, mem_wr} !== 5'b00000) begin
      errors++;
      $display("FAIL zero_cycle2 got %b exp 00000", {busy, done, err, mem_enable, mem_wr});
    end
    checks++;
    if (mem[16'h0010] !== 16'hABCD) begin
      errors++;
      $display("FAIL zero_mem got %h exp abcd", mem[16'h0010]);
    end
  endtask

  task automatic test_misaligned;
    logic [15:0] s, d;
    for (int k = 0; k < 2; k++) begin
      s = k == 0 ? 16'h0101 : 16'h0100;
      d = k == 0 ? 16'h0200 : 16'h0203;
      launch(s, d, 16'd2);
      checks++;
      if ({busy, done, err, mem_enable, mem_wr} !== 5'b00100) begin
        errors++;
        $display("FAIL misalign%0d_cycle1 got %b exp 00100", k, {busy, done, err, mem_enable, mem_wr});
      end
      @(posedge clk); #1;
      checks++;
      if ({busy, done, err, mem_enable, mem_wr} !== 5'b00000) begin
        errors++;
        $display("FAIL misalign%0d_cycle2 got %b exp 00000", k, {busy, done, err, mem_enable, mem_wr});
      end
    end
  endtask

  task automatic test_wrap;
    logic [15:0] ra [3];
    logic [15:0] wa [3];
    logic [15:0] dat [3];
    logic [20:0] got, exp;
    ra[0] = 16'hFFFC; ra[1] = 16'hFFFE; ra[2] = 16'h0000;
    wa[0] = 16'h0400; wa[1] = 16'h0402; wa[2] = 16'h0404;
    dat[0] = 16'hA001; dat[1] = 16'hA002; dat[2] = 16'hA003;
    for (int i = 0; i < 3; i++) poke(ra[i], dat[i]);
    launch(16'hFFFC, 16'h0400, 16'd3);
    for (int c = 1; c <= 7; c++) begin
      exp = c == 7 ? {5'b01000, 16'h0}
          : (c % 2 == 1) ? {5'b10010, ra[(c - 1) / 2]} : {5'b10011, wa[(c - 2) / 2]};
      got = {busy, done, err, mem_enable, mem_wr, mem_addr};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL wrap_cycle%0d got %h exp %h", c, got, exp);
      end
      @(posedge clk); #1;
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (mem[wa[i][15:1]] !== dat[i]) begin
        errors++;
        $display("FAIL wrap_mem%0d got %h exp %h", i, mem[wa[i][15:1]], dat[i]);
      end
    end
  endtask

  task automatic test_reset_mid_copy;
    logic [15:0] dat [3];
    dat[0] = 16'h5A01; dat[1] = 16'h5A02; dat[2] = 16'h5A03;
    for (int i = 0; i < 3; i++) begin
      poke(16'h0500 + 16'(2 * i), dat[i]);
      poke(16'h0600 + 16'(2 * i), 16'hDEAD);
      poke(16'h0700 + 16'(2 * i), 16'hDEAD);
    end
    launch(16'h0500, 16'h0600, 16'd3);
    for (int c = 1; c < 4; c++) begin
      @(posedge clk); #1;
    end
    checks++;
    if ({busy, mem_wr, mem_addr} !== {2'b11, 16'h0602}) begin
      errors++;
      $display("FAIL rstmid_pre got %h exp 30602", {busy, mem_wr, mem_addr});
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, err, mem_enable, mem_wr, mem_addr, mem_wdata} !== 37'd0) begin
      errors++;
      $display("FAIL rstmid_outputs got %h exp 0", {busy, done, err, mem_enable, mem_wr, mem_addr, mem_wdata});
    end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      checks++;
      if ({done, mem_enable} !== 2'b00) begin
        errors++;
        $display("FAIL rstmid_hold%0d got %b exp 00", c, {done, mem_enable});
      end
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({busy, done, mem_enable} !== 3'b000) begin
      errors++;
      $display("FAIL rstmid_idle got %b exp 000", {busy, done, mem_enable});
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (mem[16'h0300 + 16'(i)] !== (i == 0 ? dat[0] : 16'hDEAD)) begin
        errors++;
        $display("FAIL rstmid_mem%0d got %h exp %h", i, mem[16'h0300 + 16'(i)], i == 0 ? dat[0] : 16'hDEAD);
      end
    end
    launch(16'h0500, 16'h0700, 16'd3);
    for (int c = 1; c <= 7; c++) begin
      checks++;
      if ({busy, done} !== {c <= 6, c == 7}) begin
        errors++;
        $display("FAIL rstmid_rerun_cycle%0d got %b exp %b", c, {busy, done}, {c <= 6, c == 7});
      end
      @(posedge clk); #1;
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (mem[16'h0380 + 16'(i)] !== dat[i]) begin
        errors++;
        $display("FAIL rstmid_rerun_mem%0d got %h exp %h", i, mem[16'h0380 + 16'(i)], dat[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    poke(16'h0800, 16'hB001);
    poke(16'h0802, 16'hB002);
    launch(16'h0800, 16'h0900, 16'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL b2b_done1 got %b exp 1", done);
    end
    @(posedge clk); #1;
    launch(16'h0802, 16'h0902, 16'd1);
    checks++;
    if ({busy, mem_wr, mem_addr} !== {2'b10, 16'h0802}) begin
      errors++;
      $display("FAIL b2b_read2 got %h exp 20802", {busy, mem_wr, mem_addr});
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL b2b_done2 got %b exp 1", done);
    end
    checks++;
    if ({mem[16'h0480], mem[16'h0481]} !== {16'hB001, 16'hB002}) begin
      errors++;
      $display("FAIL b2b_mem got %h exp b001b002", {mem[16'h0480], mem[16'h0481]});
    end
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset;
    test_basic_copy;
    test_zero_count;
    test_misaligned;
    test_wrap;
    test_reset_mid_copy;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
